// File: rtl/io_in_byte_buffer_if.sv
// Handshake bundle between the IO input byte stream, the core read port and the buffer.
// Latency: none; this is wiring only.
// Backpressure: io_in_rdy, req_rdy and resp_rdy carry the flow control of each channel.
interface io_in_byte_buffer_if;
    // Byte stream coming from the IO controller
    logic [7:0]  io_in_data;
    logic        io_in_vld;
    logic        io_in_rdy;

    // Core read request channel
    logic        req_vld;
    logic        req_word;
    logic        req_rdy;

    // Read result channel
    logic [31:0] resp_data;
    logic        resp_vld;
    logic        resp_rdy;

    // Buffer side: consumes bytes and requests, produces results
    modport slave (
        input  io_in_data,
        input  io_in_vld,
        output io_in_rdy,
        input  req_vld,
        input  req_word,
        output req_rdy,
        output resp_data,
        output resp_vld,
        input  resp_rdy
    );

    // Environment side: IO controller plus core execution unit
    modport master (
        output io_in_data,
        output io_in_vld,
        input  io_in_rdy,
        output req_vld,
        output req_word,
        input  req_rdy,
        input  resp_data,
        input  resp_vld,
        output resp_rdy
    );
endinterface

// File: rtl/io_in_byte_buffer.sv
// Buffers IO input bytes in a FIFO and serves core byte / little-endian word reads.
// Latency: with data already buffered, resp_vld rises 1 (byte) or 4 (word) cycles after the request handshake.
// Backpressure: io_in_rdy drops when the FIFO is full; an empty FIFO stalls a read; resp held until resp_rdy.
// Optional build macro IO_IN_LEVEL_EN adds the in_level and in_full status outputs.
module io_in_byte_buffer #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    io_in_byte_buffer_if.slave       bus
`ifdef IO_IN_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]   in_level,
    output logic                     in_full
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Read sequencer states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_RESP    = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [1:0]       state_q, state_d;
    logic [2:0]       need_q, need_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      asm_q, asm_d;

    // Low while reset is held and for the first edge after release, so the
    // ready outputs stay quiet until the block has seen a clean clock edge.
    logic             run_q, run_d;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic             io_in_rdy;
    logic             push;
    logic             pop;
    logic             req_fire;
    logic             resp_fire;
    logic [7:0]       pop_byte;

    // Channel handshakes; io_in_rdy uses the pre-pop count so a full FIFO never takes a byte
    always_comb begin
        io_in_rdy = run_q && (count_q != CNT_FULL);
        push      = bus.io_in_vld && io_in_rdy;
        pop       = (state_q == ST_COLLECT) && (count_q != '0);
        req_fire  = run_q && (state_q == ST_IDLE) && bus.req_vld;
        resp_fire = (state_q == ST_RESP) && bus.resp_rdy;
        pop_byte  = mem_q[rd_ptr_q];
    end

    assign bus.io_in_rdy = io_in_rdy;
    assign bus.req_rdy   = run_q && (state_q == ST_IDLE);
    assign bus.resp_vld  = (state_q == ST_RESP);
    assign bus.resp_data = asm_q;

`ifdef IO_IN_LEVEL_EN
    assign in_level = count_q;
    assign in_full  = (count_q == CNT_FULL);
`endif

    // ------------------------------------------------------------------
    // FIFO next state: storage write, wrapping pointers, occupancy
    // ------------------------------------------------------------------
    // Storage and pointer update; pointers wrap naturally at the power-of-two depth
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.io_in_data;
        end

        wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Read sequencer: accept request, gather bytes, present result
    // ------------------------------------------------------------------
    // Request sequencing and little-endian byte assembly
    always_comb begin
        state_d = state_q;
        need_d  = need_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        run_d   = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    need_d  = bus.req_word ? 3'd4 : 3'd1;
                    idx_d   = 3'd0;
                    asm_d   = 32'h0;
                    state_d = ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                // An empty FIFO simply stalls here; there is no timeout.
                if (pop) begin
                    asm_d[{idx_q[1:0], 3'b000} +: 8] = pop_byte;
                    idx_d = idx_q + 3'd1;
                    if ((idx_q + 3'd1) == need_q) begin
                        state_d = ST_RESP;
                    end
                end
            end

            ST_RESP: begin
                // asm_q is untouched here, so resp_data holds until the core takes it.
                if (resp_fire) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sequencer state, assembly register and post-reset enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            need_q  <= 3'd0;
            idx_q   <= 3'd0;
            asm_q   <= 32'h0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            need_q  <= need_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            run_q   <= run_d;
        end
    end

endmodule
